// File: rtl/and_pipe_reg.sv
// and_pipe_reg: fixed-latency registered logic pipeline.
//   Stage 1 captures OP(a,b) bitwise; stages 2..DEPTH form a true shift
//   register behind it. q1 taps stage 1 and q2 taps stage DEPTH, so q2 lags
//   the sampled inputs by DEPTH clocks. No enable or stall: the pipeline
//   advances on every clock.
//
// Parameters:
//   WIDTH - operand / output width
//   DEPTH - total register stages from inputs to q2 (legal range 2..16)
//   OP    - combine function: 0 AND, 1 OR, 2 XOR, anything else AND
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset; clears every stage
//   a, b       in   [WIDTH] operands, sampled at posedge clk
//   q1         out  [WIDTH] stage-1 register
//   q2         out  [WIDTH] stage-DEPTH register
//   in_valid   in   (AND_PIPE_VALID_EN only) qualifies a,b
//   out_valid  out  (AND_PIPE_VALID_EN only) valid bit leaving stage DEPTH
//
// Optional feature macro: AND_PIPE_VALID_EN. When defined, a valid bit shifts
// alongside the data through every stage, and a data stage loads only when
// the valid bit arriving at it is set; otherwise that stage holds its value.
module and_pipe_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int OP    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef AND_PIPE_VALID_EN
  input  logic             in_valid,
  output logic             out_valid,
`endif
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2
);

  function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (OP)
      1:       return x | y;
      2:       return x ^ y;
      default: return x & y;
    endcase
  endfunction

  // Stage index 0 is stage 1 (q1); index DEPTH-1 is stage DEPTH (q2).
  logic [DEPTH-1:0][WIDTH-1:0] stg_q, stg_d;
  logic [DEPTH-1:0]            ld;

`ifdef AND_PIPE_VALID_EN
  // Valid bits shift unconditionally; each data stage loads on the valid
  // bit that is arriving at it on this edge.
  logic [DEPTH-1:0] vld_pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= {vld_pipe_q[DEPTH-2:0], in_valid};
  end

  assign ld        = {vld_pipe_q[DEPTH-2:0], in_valid};
  assign out_valid = vld_pipe_q[DEPTH-1];
`else
  assign ld = '1;
`endif

  // Next state reads only pre-edge register values, so all stages shift
  // together with no fall-through.
  always_comb begin
    stg_d = stg_q;
    if (ld[0]) stg_d[0] = combine(a, b);
    for (int k = 1; k < DEPTH; k++) begin
      if (ld[k]) stg_d[k] = stg_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stg_q <= '0;
    else     stg_q <= stg_d;
  end

  assign q1 = stg_q[0];
  assign q2 = stg_q[DEPTH-1];

endmodule

// File: tb/tb_and_pipe_reg.sv
module tb_and_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
  endtask

  // u0: defaults (AND, depth 2); u1: OR; u2: 8-bit XOR depth 4; u3: random
  logic       a0 = 0, b0 = 0, v0 = 1;
  logic       q1_0, q2_0, ov0;
  logic       q1_1, q2_1, ov1;
  logic [7:0] a2 = 0, b2 = 0;
  logic       v2 = 0;
  logic [7:0] q1_2, q2_2;
  logic       ov2;
  logic [7:0] a3 = 0, b3 = 0;
  logic       v3 = 0;
  logic [7:0] q1_3, q2_3;
  logic       ov3;

`ifdef AND_PIPE_VALID_EN
  and_pipe_reg #(.WIDTH(1), .DEPTH(2), .OP(0)) u0 (.clk(clk), .rst(rst), .a(a0), .b(b0),
    .in_valid(v0), .out_valid(ov0), .q1(q1_0), .q2(q2_0));
  and_pipe_reg #(.WIDTH(1), .DEPTH(2), .OP(1)) u1 (.clk(clk), .rst(rst), .a(a0), .b(b0),
    .in_valid(v0), .out_valid(ov1), .q1(q1_1), .q2(q2_1));
  and_pipe_reg #(.WIDTH(8), .DEPTH(4), .OP(2)) u2 (.clk(clk), .rst(rst), .a(a2), .b(b2),
    .in_valid(v2), .out_valid(ov2), .q1(q1_2), .q2(q2_2));
  and_pipe_reg #(.WIDTH(8), .DEPTH(3), .OP(2)) u3 (.clk(clk), .rst(rst), .a(a3), .b(b3),
    .in_valid(v3), .out_valid(ov3), .q1(q1_3), .q2(q2_3));
`else
  and_pipe_reg #(.WIDTH(1), .DEPTH(2), .OP(0)) u0 (.clk(clk), .rst(rst), .a(a0), .b(b0),
    .q1(q1_0), .q2(q2_0));
  and_pipe_reg #(.WIDTH(1), .DEPTH(2), .OP(1)) u1 (.clk(clk), .rst(rst), .a(a0), .b(b0),
    .q1(q1_1), .q2(q2_1));
  and_pipe_reg #(.WIDTH(8), .DEPTH(4), .OP(2)) u2 (.clk(clk), .rst(rst), .a(a2), .b(b2),
    .q1(q1_2), .q2(q2_2));
  and_pipe_reg #(.WIDTH(8), .DEPTH(3), .OP(2)) u3 (.clk(clk), .rst(rst), .a(a3), .b(b3),
    .q1(q1_3), .q2(q2_3));
  assign ov0 = 1'b0;
  assign ov1 = 1'b0;
  assign ov2 = 1'b0;
  assign ov3 = 1'b0;
`endif

  // Directed vectors for u0 (AND) and u1 (OR), both fed from a0/b0.
  typedef struct packed {
    logic a, b, and_q1, and_q2, or_q1, or_q2;
  } vec_t;
  vec_t tbl[10];

  function automatic vec_t mk(input int a, b, aq1, aq2, oq1, oq2);
    vec_t v;
    v.a = a[0]; v.b = b[0]; v.and_q1 = aq1[0]; v.and_q2 = aq2[0];
    v.or_q1 = oq1[0]; v.or_q2 = oq2[0];
    return v;
  endfunction

  // Reference model for u3: each stage k holds the most recent valid sample
  // taken at least k edges ago (zero if none since reset).
  localparam int D3 = 3;
  typedef struct packed { logic [7:0] a, b; logic v; } smp_t;
  smp_t hist[$];

  function automatic logic [7:0] exp_stage(input int k);
    for (int i = hist.size() - k; i >= 0; i--)
      if (hist[i].v) return hist[i].a ^ hist[i].b;
    return 8'h00;
  endfunction

  function automatic logic exp_ov3();
    if (hist.size() < D3) return 1'b0;
    return hist[hist.size() - D3].v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic vf;
`ifdef AND_PIPE_VALID_EN
    vf = 1'b1;
`else
    vf = 1'b0;
`endif
    tbl[0] = mk(1, 1, 1, 0, 1, 0);
    tbl[1] = mk(1, 1, 1, 1, 1, 1);
    tbl[2] = mk(0, 1, 0, 1, 1, 1);
    tbl[3] = mk(0, 1, 0, 0, 1, 1);
    tbl[4] = mk(0, 0, 0, 0, 0, 1);
    tbl[5] = mk(1, 0, 0, 0, 1, 0);
    tbl[6] = mk(1, 0, 0, 0, 1, 1);
    tbl[7] = mk(1, 0, 0, 0, 1, 1);
    tbl[8] = mk(1, 1, 1, 0, 1, 1);
    tbl[9] = mk(1, 1, 1, 1, 1, 1);

    // Reset held across two edges
    step(); step();
    chk("rst_q1", 32'(q1_0), 0);
    chk("rst_q2", 32'(q2_0), 0);
    chk("rst_wide_q2", 32'(q2_2), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      a0 = tbl[i].a; b0 = tbl[i].b;
      step();
      chk($sformatf("and_q1[%0d]", i), 32'(q1_0), 32'(tbl[i].and_q1));
      chk($sformatf("and_q2[%0d]", i), 32'(q2_0), 32'(tbl[i].and_q2));
      chk($sformatf("or_q1[%0d]", i),  32'(q1_1), 32'(tbl[i].or_q1));
      chk($sformatf("or_q2[%0d]", i),  32'(q2_1), 32'(tbl[i].or_q2));
      if (vf) chk($sformatf("ov0[%0d]", i), 32'(ov0 & ov1), 32'(i >= 1));
    end

    // Mid-cycle reset while q2=1: clears without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("midrst_q2", 32'(q2_0), 0);
    chk("midrst_q1", 32'(q1_0), 0);
    @(negedge clk);
    rst = 1'b0;
    // a=b=1 still applied: zeros refill ahead of new data
    step();
    chk("refill_q1", 32'(q1_0), 1);
    chk("refill_q2", 32'(q2_0), 0);
    step();
    chk("refill2_q2", 32'(q2_0), 1);

    // Wide/deep XOR pulse
    a2 = 8'hF0; b2 = 8'h3C; v2 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      a2 = 8'h00; b2 = 8'h00; v2 = 1'b0;
      if (vf) begin
        chk($sformatf("wide_q1[%0d]", c), 32'(q1_2), 32'h0CC);
        chk($sformatf("wide_q2[%0d]", c), 32'(q2_2), (c >= 4) ? 32'h0CC : 32'h0);
        chk($sformatf("wide_ov[%0d]", c), 32'(ov2), 32'(c == 4));
      end else begin
        chk($sformatf("wide_q1[%0d]", c), 32'(q1_2), (c == 1) ? 32'h0CC : 32'h0);
        chk($sformatf("wide_q2[%0d]", c), 32'(q2_2), (c == 4) ? 32'h0CC : 32'h0);
      end
    end

    // Randomized run on u3 against the history model
    rst = 1'b1;
    step();
    rst = 1'b0;
    hist.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      a3 = 8'($urandom);
      b3 = 8'($urandom);
      v3 = vf ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 150) begin
        rst = 1'b1;
        #1;
        chk("rnd_rst_q2", 32'(q2_3), 0);
        hist.delete();
      end
      @(posedge clk);
      if (!rst) hist.push_back({a3, b3, v3});
      @(negedge clk);
      rst = 1'b0;
      chk($sformatf("rnd_q1[%0d]", cyc), 32'(q1_3), 32'(exp_stage(1)));
      chk($sformatf("rnd_q2[%0d]", cyc), 32'(q2_3), 32'(exp_stage(D3)));
      if (vf) chk($sformatf("rnd_ov[%0d]", cyc), 32'(ov3), 32'(exp_ov3()));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/and_pipe_reg.md
Name: and_pipe_reg

Overview:
- Small registered logic pipeline: combines two inputs bitwise (default AND), registers the result, then delays it through further register stages.
- Used as a reference sequential block for nonblocking-assignment idioms and as a generic fixed-latency gated-condition delay line.
- Default configuration: q1 = registered (a & b); q2 = q1 delayed one more clock, so q2 lags the inputs by exactly 2 clocks.

Parameters:
- WIDTH, 1: bit width of a, b, q1, q2.
- DEPTH, 2: total register stages from inputs to q2; legal range 2..16. Stage 1 drives q1; stage DEPTH drives q2.
- OP, 0: combine function applied before stage 1. 0 = AND, 1 = OR, 2 = XOR. Any other value behaves as AND.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A, sampled at posedge clk.
- b  input  WIDTH  operand B, sampled at posedge clk.
- q1  output  WIDTH  stage-1 register: OP(a,b) one clock after sampling.
- q2  output  WIDTH  final stage register: OP(a,b) DEPTH clocks after sampling.

Behaviour:
- Reset: while rst=1, every stage register clears to 0 immediately, without waiting for a clock edge, so q1=0 and q2=0. Reset dominates clk.
- Reset release: the first capture happens at the first posedge clk with rst=0.
- Stage 1, each posedge: q1 <= OP(a,b), computed bitwise over WIDTH.
- Stage k (2..DEPTH), each posedge: stage[k] <= stage[k-1]. All stages update simultaneously using pre-edge values (true shift, no fall-through); q2 = stage[DEPTH].
- Latency: an input change sampled at edge N appears on q1 after edge N and on q2 after edge N+DEPTH-1. Default DEPTH=2 gives a 2-edge input-to-q2 latency.
- Outputs come directly from registers; there is no combinational path from a or b to q1 or q2.
- Inputs must be stable around posedge; glitches between edges have no effect.
- Reset mid-operation: all in-flight data is discarded. After release the pipeline refills with zeros ahead of new data, so q2 stays 0 for at least DEPTH-1 edges after the first post-release capture.
- No enable, no stall; the pipeline advances every clock.

Optional Feature:
- Macro: AND_PIPE_VALID_EN.
- Defined: adds ports in_valid (input, 1) and out_valid (output, 1).
  - A valid bit travels alongside the data through all DEPTH stages.
  - out_valid resets to 0 asynchronously with rst.
  - A data stage loads only when its incoming valid bit is 1; otherwise it holds its value.
  - Valid bits themselves always shift.
- Undefined: no extra ports; every stage loads every clock, as described in Behaviour.

Test Plan:
- Reset: hold rst=1 with a=b=0 across 2 posedges -> q1=0, q2=0. Assert rst=1 mid-cycle while q2=1 -> q2 drops to 0 before the next edge.
- Basic latency (defaults): release rst at a negedge, then set a=1, b=1 -> q1=1 after the next posedge; q2=1 after the following posedge.
- Operand drop: from the steady a=b=1 state, set a=0 at a negedge -> q1=0 after the next posedge, q2=0 one posedge later. Then set b=0 -> q1, q2 remain 0.
- Only-one-high: a=1, b=0 for 3 clocks -> q1 and q2 stay 0 (AND). Repeat with OP=1 -> q1=1, then q2=1 one clock later.
- Wide/deep: WIDTH=8, DEPTH=4, OP=2; apply a=8'hF0, b=8'h3C for one clock, then zeros -> q1=8'hCC for exactly one cycle; q2=8'hCC exactly 3 cycles later for one cycle.
- Valid feature: with AND_PIPE_VALID_EN defined, send data with in_valid=1 for 1 clock, then in_valid=0 -> out_valid pulses high for exactly 1 cycle, DEPTH edges later. q2 holds that value afterward.
